native_mem_ctrl: RTL and testbench

//  Initiator-side controller that drives the single-port synchronous word RAM
//  (en/write/addr/data_in -> data_out, 1-cycle registered read, no byte enables).

---
 rtl/native_mem_ctrl.sv | 136 +++++++++++++
 tb/tb_native_mem_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/native_mem_ctrl.sv
// Native-bus initiator for a single-port synchronous word RAM.
// Partial-word stores are done as read-modify-write.
module native_mem_ctrl #(
  parameter int unsigned SIZE      = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            mem_valid,
  input  logic [31:0]     mem_addr,
  input  logic [31:0]     mem_wdata,
  input  logic [3:0]      mem_wstrb,
  output logic            mem_ready,
  output logic [31:0]     mem_rdata,
  output logic            ram_en,
  output logic            ram_write,
  output logic [SIZE-1:0] ram_addr,
  output logic [31:0]     ram_wdata,
  input  logic [31:0]     ram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    RMW_WAIT,
    RMW_WR,
    WR_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            en_q, en_d;
  logic            write_q, write_d;
  logic [SIZE-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     cap_wdata_q, cap_wdata_d;
  logic [3:0]      cap_wstrb_q, cap_wstrb_d;

  logic [31:0] offset;
  logic        hit;
  logic [31:0] merged;

  // BASE_ADDR is aligned, so addresses below it wrap high and miss
  assign offset = mem_addr - BASE_ADDR;
  assign hit    = (offset >> (SIZE + 2)) == 32'd0;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = cap_wstrb_q[i] ? cap_wdata_q[8*i +: 8]
                                        : ram_rdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    rdata_d     = 32'd0;
    en_d        = 1'b0;
    write_d     = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cap_wdata_d = cap_wdata_q;
    cap_wstrb_d = cap_wstrb_q;
    unique case (state_q)
      IDLE: begin
        if (mem_valid && hit) begin
          en_d        = 1'b1;
          addr_d      = offset[SIZE+1:2];
          cap_wdata_d = mem_wdata;
          cap_wstrb_d = mem_wstrb;
          unique case (1'b1)
            (mem_wstrb == 4'h0): state_d = RD_WAIT;
            (mem_wstrb == 4'hF): begin
              write_d = 1'b1;
              wdata_d = mem_wdata;
              state_d = WR_DONE;
            end
            default: state_d = RMW_WAIT;
          endcase
        end
      end
      RD_WAIT:  state_d = RD_DONE;
      RD_DONE: begin
        ready_d = 1'b1;
        rdata_d = ram_rdata;
        state_d = IDLE;
      end
      RMW_WAIT: state_d = RMW_WR;
      RMW_WR: begin
        en_d    = 1'b1;
        write_d = 1'b1;
        wdata_d = merged;
        state_d = WR_DONE;
      end
      WR_DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rdata_q     <= 32'd0;
      en_q        <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      cap_wdata_q <= 32'd0;
      cap_wstrb_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      en_q        <= en_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cap_wdata_q <= cap_wdata_d;
      cap_wstrb_q <= cap_wstrb_d;
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign ram_en    = en_q;
  assign ram_write = write_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_native_mem_ctrl.sv
// Bench for native_mem_ctrl: behavioural RAM, word-level reference
// memory, directed steps followed by randomized transactions.
module tb_native_mem_ctrl;

  localparam int unsigned SIZE  = 14;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned DEPTH = 2 ** SIZE;
  localparam logic [31:0] TOP   = BASE + 32'(4 * (DEPTH - 1));
  localparam logic [31:0] MISS  = BASE + 32'(4 * DEPTH);

  logic            clk = 1'b0;
  logic            resetn;
  logic            mem_valid;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ready;
  logic [31:0]     mem_rdata;
  logic            ram_en;
  logic            ram_write;
  logic [SIZE-1:0] ram_addr;
  logic [31:0]     ram_wdata;
  logic [31:0]     ram_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] ram_mem [0:DEPTH-1];
  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  native_mem_ctrl #(.SIZE(SIZE), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .ram_en    (ram_en),
    .ram_write (ram_write),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_write) ram_mem[ram_addr] <= ram_wdata;
      else           ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(mem_ready), 32'd0);
    chk({tag, "_rdata"}, mem_rdata, 32'd0);
    chk({tag, "_en"}, 32'(ram_en), 32'd0);
    chk({tag, "_write"}, 32'(ram_write), 32'd0);
    chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_wdata"}, ram_wdata, 32'd0);
  endtask

  // One bus transaction; starts #1 after a rising edge.
  task automatic txn(input string tag, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] ws,
                     input bit drop, output logic [31:0] rd);
    int          w, lat, en_n, wr_n, leak, exp_lat, exp_en;
    logic [31:0] exp_rd, old;
    logic [31:0] a0;
    bit          done;
    w = int'((a - BASE) >> 2);
    exp_lat = (ws == 4'h0) ? 3 : (ws == 4'hF) ? 2 : 4;
    exp_en  = (ws == 4'h0 || ws == 4'hF) ? 1 : 2;
    exp_rd  = 32'd0;
    if (ws == 4'h0) begin
      exp_rd = ref_mem[w];
    end else begin
      old = ref_mem.exists(w) ? ref_mem[w] : 32'd0;
      for (int b = 0; b < 4; b++)
        if (ws[b]) old[8*b +: 8] = wd[8*b +: 8];
      ref_mem[w] = old;
    end
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    lat = 0; en_n = 0; wr_n = 0; leak = 0; done = 0;
    rd = 32'd0; a0 = 32'd0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) a0 = 32'(ram_addr);
      if (ram_en) en_n++;
      if (ram_write) wr_n++;
      if (drop && lat == 1) begin
        mem_valid = 1'b0;
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom);
      end
      if (mem_ready) begin
        done = 1;
        rd   = mem_rdata;
      end else if (mem_rdata !== 32'd0) begin
        leak++;
      end
    end
    mem_valid = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_ram_addr"}, a0, 32'(w));
    chk({tag, "_en_cycles"}, 32'(en_n), 32'(exp_en));
    chk({tag, "_wr_cycles"}, 32'(wr_n), (ws == 4'h0) ? 32'd0 : 32'd1);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_rdata_idle"}, 32'(leak), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int          hits;
    int          w;
    logic [3:0]  ws;
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wstrb = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      w = (i == 16) ? (DEPTH - 1) : i;
      txn($sformatf("init%0d", i), BASE + 32'(4 * w), $urandom, 4'hF, 1'b0, rd);
    end

    txn("t2_wr", BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, rd);
    txn("t2_rd", BASE + 32'h10, 32'd0, 4'h0, 1'b0, rd);
    chk("t2_value", rd, 32'hDEAD_BEEF);

    txn("t3_wr", BASE + 32'h20, 32'h1122_3344, 4'hF, 1'b0, rd);
    txn("t3_rmw", BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, rd);
    txn("t3_rd", BASE + 32'h20, 32'd0, 4'h0, 1'b0, rd);
    chk("t3_value", rd, 32'h11BB_33DD);

    txn("t1_wr", BASE + 32'h30, 32'h5566_7788, 4'hF, 1'b0, rd);
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h30;
    mem_wdata = 32'h0;
    mem_wstrb = 4'b0011;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk_idle_outputs("t1_async");
    mem_valid = 1'b0;
    hits = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ram_en || mem_ready) hits++;
    end
    chk("t1_quiet", 32'(hits), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    txn("t1_rd", BASE + 32'h30, 32'd0, 4'h0, 1'b0, rd);
    chk("t1_value", rd, 32'h5566_7788);

    mem_valid = 1'b1;
    mem_addr  = MISS;
    mem_wdata = 32'h1234_5678;
    mem_wstrb = 4'hF;
    hits = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ram_en || mem_ready) hits++;
    end
    mem_valid = 1'b0;
    chk("t4_miss", 32'(hits), 32'd0);

    txn("t5_rd0", BASE, 32'd0, 4'h0, 1'b0, rd);
    txn("t5_top", TOP, 32'hCAFE_F00D, 4'hF, 1'b0, rd);
    txn("t5_rdtop", TOP, 32'd0, 4'h0, 1'b0, rd);
    chk("t5_value", rd, 32'hCAFE_F00D);

    for (int i = 0; i < 60; i++) begin
      w = $urandom_range(0, 16);
      if (w == 16) w = DEPTH - 1;
      case ($urandom_range(0, 2))
        0:       ws = 4'h0;
        1:       ws = 4'hF;
        default: ws = 4'($urandom_range(1, 14));
      endcase
      txn($sformatf("rnd%0d", i), BASE + 32'(4 * w) + 32'($urandom_range(0, 3)),
          $urandom, ws, ($urandom_range(0, 3) == 0), rd);
    end

    @(posedge clk); #1;
    chk("final_ready_low", 32'(mem_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
